// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and constants for the gate truth-table checker.
//   gate_chk_state_e : sweep sequencer states
//   TT_*             : expected truth tables for 2-input gates, bit i = y at stim == i
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_chk_settle_timer.sv
// gate_chk_settle_timer: loadable down-counter timing the settle interval.
//   clk, rst_n : clock, async active-low reset
//   load       : reload counter with SETTLE_CYCLES-1 (first settle cycle follows)
//   en         : count down while nonzero
//   expired    : counter at zero, i.e. the current cycle is the last settle cycle
module gate_chk_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Width floors at 1 so a zero-settle build still elaborates; the timer is
  // simply never loaded in that case.
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_VAL;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks every input combination of a small gate under test,
// waits SETTLE_CYCLES, samples dut_y and compares against EXP_TT.
//   clk, rst_n : clock (rising), async active-low reset
//   start      : begin a sweep (only honoured in IDLE)
//   dut_y      : gate under test output
//   stim       : gate inputs, MSB = a
//   busy       : sweep in progress (SETTLE/SAMPLE)
//   done       : one-cycle end-of-sweep pulse
//   pass       : last sweep had no mismatches, held until next start
//   err_count  : mismatches in current/last sweep
//   fail_vec   : per-row mismatch flags
// Optional: define GATE_TT_CHECKER_LOG_EN to print per-row and summary lines
// in simulation; behaviour is otherwise identical.
module gate_tt_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_AND
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [(1<<N_IN)-1:0] fail_vec
);

  localparam int              ROWS      = 1 << N_IN;
  localparam bit              NO_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [N_IN-1:0] ROW_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

  gate_chk_state_e   state_q, state_d;
  logic [N_IN-1:0]   row_q, row_d;
  logic [N_IN:0]     err_q, err_d;
  logic [ROWS-1:0]   fv_q, fv_d;
  logic              pass_q, pass_d;
  logic              timer_load, timer_en, timer_expired;
  logic              exp_bit, mismatch;

  gate_chk_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Mismatch defaults to 1 and is cleared only on a clean equality, so an
  // X/Z on dut_y (equality unknown) is scored as a failure.
  always_comb begin
    exp_bit  = EXP_TT[row_q];
    mismatch = 1'b1;
    if (dut_y == exp_bit) mismatch = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    err_d      = err_q;
    fv_d       = fv_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = '0;
          fv_d   = '0;
          pass_d = 1'b0;
          row_d  = '0;
          if (NO_SETTLE) begin
            state_d = SAMPLE;
          end else begin
            state_d    = SETTLE;
            timer_load = 1'b1;
          end
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_expired) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          fv_d[row_q] = 1'b1;
          err_d       = err_q + ERR_ONE;
        end
        if (&row_q) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          row_d = row_q + ROW_ONE;
          if (NO_SETTLE) begin
            state_d = SAMPLE;
          end else begin
            state_d    = SETTLE;
            timer_load = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      err_q   <= '0;
      fv_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  // stim is the row index itself, so it only moves on SAMPLE->next row
  // (or is zeroed by start in IDLE).
  assign stim      = row_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

`ifdef GATE_TT_CHECKER_LOG_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == SAMPLE) begin
        for (int i = N_IN - 1; i >= 0; i--) $write("%b ", row_q[i]);
        $display("| %b %b%s", dut_y, exp_bit, mismatch ? " FAIL" : "");
      end
      if (state_q == DONE) begin
        if (err_q == '0) $display("PASS");
        else             $display("FAIL %0d", err_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed bench. u_dut uses defaults (AND, settle 2)
// against a selectable gate model; u_dut0 uses settle 0 and an XOR table.
module tb_gate_tt_checker;
  import gate_chk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start0 = 1'b0;
  logic [1:0] stim, stim0;
  logic       dut_y, dut0_y;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [2:0] err, err0;
  logic [3:0] fv, fv0;
  int         gsel = 0;
  int         errors = 0, checks = 0;

  always #5 clk = ~clk;

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // 0: AND built from NORs, 1: OR, 2: AND with X on row 3
  always_comb begin
    dut_y = 1'b0;
    case (gsel)
      0:       dut_y = nor2(nor2(stim[1], stim[1]), nor2(stim[0], stim[0]));
      1:       dut_y = stim[1] | stim[0];
      default: dut_y = (stim == 2'd3) ? 1'bx : (stim[1] & stim[0]);
    endcase
  end
  assign dut0_y = stim0[1] ^ stim0[0];

  gate_tt_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_y(dut_y), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .err_count(err), .fail_vec(fv)
  );

  gate_tt_checker #(.N_IN(2), .SETTLE_CYCLES(0), .EXP_TT(TT_XOR)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(dut0_y), .stim(stim0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Full default sweep from a negedge: stim walks 0..3 held 3 cycles each,
  // done on cycle 13. poke re-pulses start at cycle 6 (must be ignored).
  task automatic sweep(input logic [3:0] efv, input int eerr, input bit epass, input bit poke);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) begin
        chk("stim", stim, (c - 1) / 3);
        chk("busy", busy, 1);
        chk("done_early", done, 0);
      end else begin
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("pass", pass, epass);
        chk("err_count", err, eerr);
        chk("fail_vec", fv, efv);
      end
      if (poke) start = (c == 6);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("pass_held", pass, epass);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err, 0);
    chk("rst_fv", fv, 0);
    chk("rst_busy0", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    gsel = 0; sweep(4'b0000, 0, 1'b1, 1'b0);
    gsel = 1; sweep(4'b0110, 2, 1'b0, 1'b0);
    gsel = 0; sweep(4'b0000, 0, 1'b1, 1'b1);
    gsel = 2; sweep(4'b1000, 1, 1'b0, 1'b0);

    // zero-settle XOR: stim advances every cycle, done on cycle 5
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c <= 4) begin
        chk("stim0", stim0, c - 1);
        chk("busy0", busy0, 1);
      end else begin
        chk("done0", done0, 1);
        chk("pass0", pass0, 1);
        chk("err0", err0, 0);
        chk("fv0", fv0, 0);
      end
      @(negedge clk);
    end

    // async reset during row 2 SETTLE with an OR gate (row 1 already failed)
    gsel = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_stim", stim, 2);
    chk("pre_rst_fv", fv, 4'b0010);
    chk("pre_rst_err", err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stim", stim, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_err", err, 0);
    chk("arst_fv", fv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    gsel = 0; sweep(4'b0000, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Self-checking stimulus sequencer for small combinational gate networks, such as AND/OR/XOR built from NOR or NAND primitives.
- Sits upstream and downstream of the gate under test: drives every input combination in order, waits a settle interval, samples the gate output and compares it against an expected truth table.
- Reports per-row failures, an error count and a pass flag, so lab gate exercises are verified in hardware/sim without a hand-read truth table.

Parameters:
- N_IN, 2, number of gate inputs; rows = 2**N_IN.
- SETTLE_CYCLES, 2, clocks between driving a row and sampling it; 0 legal.
- EXP_TT, 4'b1000, expected output per row, width 2**N_IN; bit i = expected y when stim == i. Default is AND.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- dut_y  in  1  output of the gate under test.
- stim  out  N_IN  gate inputs; stim[N_IN-1] = a (MSB), stim[0] = last input.
- busy  out  1  high from the cycle after start through the last SAMPLE.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  1 iff the last completed sweep had zero mismatches; held until the next start.
- err_count  out  N_IN+1  mismatches in the current/last sweep.
- fail_vec  out  2**N_IN  bit i set if row i mismatched.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; stim = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, row index = 0, settle count = 0. Release takes effect on the next clk edge.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start = 1 clears err_count, fail_vec, pass and row index; stim = 0; busy = 1. Goes to SETTLE, or directly to SAMPLE if SETTLE_CYCLES = 0.
- SETTLE: stim is held; stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: one cycle. If dut_y differs from EXP_TT[row], set fail_vec[row] and increment err_count.
  - X/Z on dut_y counts as a mismatch.
  - If row = 2**N_IN - 1, go to DONE.
  - Otherwise row++, stim = row+1, and go to SETTLE (or SAMPLE if SETTLE_CYCLES = 0).
- DONE: one cycle. done = 1, busy = 0, pass = (err_count == 0). Then IDLE.
- Latency: a sweep occupies 2**N_IN × (SETTLE_CYCLES+1) cycles from the first busy cycle; done follows 1 cycle later. Default: 4 × 3 = 12, done on cycle 13.
- Boundaries:
  - start while busy or in DONE is ignored (no restart, no queueing).
  - start held high continuously starts a new sweep on each IDLE visit; the DONE→IDLE gap is 1 cycle.
  - err_count saturates only by construction (max 2**N_IN fits in N_IN+1 bits).
  - Reset mid-sweep aborts immediately, with all outputs at reset values.
  - stim changes only on the SAMPLE→next-row transition, never within SETTLE.

Optional Feature:
- Macro GATE_TT_CHECKER_LOG_EN.
- Defined: in SAMPLE, simulation prints one line per row: "a b | y exp", with "FAIL" appended on mismatch. DONE prints "PASS" or "FAIL n".
- Undefined: no display code compiled; RTL behaviour identical.

Decomposition:
- Package gate_chk_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - truth-table constants for N_IN = 2: TT_AND = 4'b1000, TT_OR = 4'b1110, TT_NAND = 4'b0111, TT_NOR = 4'b0001, TT_XOR = 4'b0110, TT_XNOR = 4'b1001.
- One sub-module: gate_chk_settle_timer.
  - Loadable down-counter, $clog2(SETTLE_CYCLES+1) bits.
  - Inputs load and en; output expired.
  - Same clk/rst_n.

Test Plan:
- Connect the NOR-built AND gate, EXP_TT = TT_AND, pulse start → stim walks 0, 1, 2, 3, each held 3 cycles. done on cycle 13, pass = 1, err_count = 0, fail_vec = 4'b0000.
- Same setup with an OR gate as the DUT → fail_vec = 4'b0110, err_count = 2, pass = 0.
- SETTLE_CYCLES = 0, EXP_TT = TT_XOR, correct XOR DUT → stim changes every cycle, done on cycle 5, pass = 1.
- Pulse start again at cycle 6 of a running sweep → no effect; sweep completes at the original time with unchanged results.
- Assert rst_n = 0 asynchronously mid-SETTLE on row 2 → all outputs 0 immediately, before the next edge. After release plus start, a full clean sweep runs.
- Drive dut_y = X on row 3 with TT_AND → fail_vec[3] = 1, err_count = 1, pass = 0.
